traffic_lane: RTL and testbench

- Consumes the 10-bit pseudo-random word from the game's LFSR and drives the car occupancy of one road lane in the crossing game.
- Holds a WIDTH-cell occupancy shift register.
- Advances the register one cell every PERIOD game ticks.
- Decides at each advance whether a new car enters, by comparing the random word against a threshold, with a minimum spacing between cars.
- One instance per lane; outputs feed the display renderer and the collision checker.

---
 rtl/traffic_pkg.sv | 14 +
 rtl/traffic_lane_if.sv | 51 +++++
 rtl/step_divider.sv | 26 ++
 rtl/traffic_lane.sv | 131 +++++++++++++
 tb/tb_traffic_lane.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the crossing-game road lanes
package traffic_pkg;

    localparam int RAND_W = 10;

    localparam logic [RAND_W-1:0] SPAWN_THRESH_DEFAULT = 10'd256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        GAP   = 2'd2
    } lane_state_t;

endpackage

// File: rtl/traffic_lane_if.sv
// rtl/traffic_lane_if.sv - lane control/occupancy bundle (clear exists only with TRAFFIC_LANE_CLEAR_EN)
interface traffic_lane_if #(
    parameter int WIDTH = 16
);
    import traffic_pkg::*;

    logic              enable;
    logic              tick;
    logic [RAND_W-1:0] rand_in;
    logic [WIDTH-1:0]  lane;
    logic              spawned;

`ifdef TRAFFIC_LANE_CLEAR_EN
    logic              clear;

    modport master (
        output enable,
        output tick,
        output rand_in,
        output clear,
        input  lane,
        input  spawned
    );

    modport slave (
        input  enable,
        input  tick,
        input  rand_in,
        input  clear,
        output lane,
        output spawned
    );
`else
    modport master (
        output enable,
        output tick,
        output rand_in,
        input  lane,
        input  spawned
    );

    modport slave (
        input  enable,
        input  tick,
        input  rand_in,
        output lane,
        output spawned
    );
`endif

endinterface

// File: rtl/step_divider.sv
// rtl/step_divider.sv - divides game ticks by PERIOD into a one-cycle step strobe
module step_divider #(
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic tick,
    output logic step
);

    logic [7:0] tick_cnt;

    // The step is combinational so the owner acts on the same edge the last tick lands on.
    assign step = enable && tick && (tick_cnt == 8'(PERIOD - 1));

    // Count enabled ticks, wrapping on the step; the count holds while disabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (enable && tick) begin
            tick_cnt <= step ? '0 : tick_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/traffic_lane.sv
// rtl/traffic_lane.sv - one road lane: occupancy shift register with gated random car spawning; optional clear input via TRAFFIC_LANE_CLEAR_EN
module traffic_lane
    import traffic_pkg::*;
#(
    parameter int                WIDTH        = 16,
    parameter int                PERIOD       = 4,
    parameter int                MIN_GAP      = 3,
    parameter logic [RAND_W-1:0] SPAWN_THRESH = SPAWN_THRESH_DEFAULT,
    parameter bit                DIR          = 1'b0
) (
    input logic           clk,
    input logic           reset,
    traffic_lane_if.slave bus
);

    lane_state_t      state, state_n;
    logic [3:0]       gap_cnt, gap_n;
    logic [WIDTH-1:0] lane_q, lane_n;
    logic             spawned_q, spawned_n;
    logic             spawn_bit;
    logic             running;
    logic             div_reset;
    logic             step;

    // Ticks only count once the lane has left IDLE, so the arming cycle swallows its tick.
    assign running = bus.enable && (state != IDLE);

`ifdef TRAFFIC_LANE_CLEAR_EN
    // A level restart zeroes the tick phase exactly like a reset does.
    assign div_reset = reset && !bus.clear;
`else
    assign div_reset = reset;
`endif

    step_divider #(
        .PERIOD (PERIOD)
    ) u_step_divider (
        .clk    (clk),
        .reset  (div_reset),
        .enable (running),
        .tick   (tick_gate(bus.tick)),
        .step   (step)
    );

    // Pass-through kept as a function so the tick feeding the divider is named in one place.
    function automatic logic tick_gate(input logic t);
        return t;
    endfunction

    // Next-state: arming, spawn decision, gap countdown and the lane shift on each step.
    always_comb begin
        state_n   = state;
        gap_n     = gap_cnt;
        lane_n    = lane_q;
        spawned_n = 1'b0;
        spawn_bit = 1'b0;

        if (!bus.enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_n = ARMED;
                    gap_n   = '0;
                end
                ARMED: begin
                    if (step) begin
                        spawn_bit = (bus.rand_in < SPAWN_THRESH);
                        if (spawn_bit) begin
                            state_n = GAP;
                            gap_n   = 4'(MIN_GAP);
                        end
                    end
                end
                GAP: begin
                    if (step) begin
                        if (gap_cnt <= 4'd1) begin
                            gap_n   = '0;
                            state_n = ARMED;
                        end else begin
                            gap_n = gap_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if (step) begin
                if (DIR) begin
                    lane_n = {spawn_bit, lane_q[WIDTH-1:1]};
                end else begin
                    lane_n = {lane_q[WIDTH-2:0], spawn_bit};
                end
                spawned_n = spawn_bit;
            end
        end

`ifdef TRAFFIC_LANE_CLEAR_EN
        // Clear empties the lane and opens with a full gap so no car appears at the kerb instantly.
        if (bus.clear) begin
            lane_n    = '0;
            spawned_n = 1'b0;
            if (bus.enable) begin
                state_n = GAP;
                gap_n   = 4'(MIN_GAP);
            end
        end
`endif
    end

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            lane_q    <= '0;
            spawned_q <= 1'b0;
        end else begin
            state     <= state_n;
            gap_cnt   <= gap_n;
            lane_q    <= lane_n;
            spawned_q <= spawned_n;
        end
    end

    assign bus.lane    = lane_q;
    assign bus.spawned = spawned_q;

endmodule

// File: tb/tb_traffic_lane.sv
// tb/tb_traffic_lane.sv - self-checking bench for traffic_lane, both shift directions side by side
module tb_traffic_lane;
    import traffic_pkg::*;

    localparam int          W  = 16;
    localparam int          P  = 2;
    localparam int          G  = 3;
    localparam logic [9:0]  TH = 10'd256;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic [9:0] rand_in;

    always #5 clk = ~clk;

    traffic_lane_if #(.WIDTH(W)) bus0 ();
    traffic_lane_if #(.WIDTH(W)) bus1 ();

    assign bus0.enable  = enable;
    assign bus0.tick    = tick;
    assign bus0.rand_in = rand_in;
    assign bus1.enable  = enable;
    assign bus1.tick    = tick;
    assign bus1.rand_in = rand_in;
`ifdef TRAFFIC_LANE_CLEAR_EN
    assign bus0.clear   = 1'b0;
    assign bus1.clear   = 1'b0;
`endif

    traffic_lane #(
        .WIDTH(W), .PERIOD(P), .MIN_GAP(G), .SPAWN_THRESH(TH), .DIR(1'b0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    traffic_lane #(
        .WIDTH(W), .PERIOD(P), .MIN_GAP(G), .SPAWN_THRESH(TH), .DIR(1'b1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] l0;
        logic [15:0] l1;
        logic        s0;
        logic        s1;
    } exp_t;

    exp_t sb[$];

    int          m_state = 0;
    int          m_gap   = 0;
    int          m_tcnt  = 0;
    logic [15:0] m_lane0 = '0;
    logic [15:0] m_lane1 = '0;
    logic        m_sp    = 1'b0;

    task automatic model_edge();
        logic b;
        if (!reset) begin
            m_state = 0; m_gap = 0; m_tcnt = 0;
            m_lane0 = '0; m_lane1 = '0; m_sp = 1'b0;
        end else if (!enable) begin
            m_state = 0; m_sp = 1'b0;
        end else if (m_state == 0) begin
            m_state = 1; m_gap = 0; m_sp = 1'b0;
        end else begin
            m_sp = 1'b0;
            if (tick) begin
                if (m_tcnt == P - 1) begin
                    m_tcnt  = 0;
                    b       = (m_state == 1) && (rand_in < TH);
                    m_lane0 = {m_lane0[14:0], b};
                    m_lane1 = {b, m_lane1[15:1]};
                    m_sp    = b;
                    if (b) begin
                        m_state = 2;
                        m_gap   = G;
                    end else if (m_state == 2) begin
                        m_gap--;
                        if (m_gap == 0) m_state = 1;
                    end
                end else begin
                    m_tcnt++;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic t, input logic [9:0] rv);
        exp_t x;
        reset   = r;
        enable  = e;
        tick    = t;
        rand_in = rv;
        model_edge();
        sb.push_back('{l0: m_lane0, l1: m_lane1, s0: m_sp, s1: m_sp});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("sb_lane0",    32'(bus0.lane),    32'(x.l0));
        check("sb_lane1",    32'(bus1.lane),    32'(x.l1));
        check("sb_spawned0", 32'(bus0.spawned), 32'(x.s0));
        check("sb_spawned1", 32'(bus1.spawned), 32'(x.s1));
    endtask

    int sp_seen;

    initial begin
        reset = 1'b0; enable = 1'b0; tick = 1'b0; rand_in = '0;

        phase = "reset";
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("lane", 32'(bus0.lane), 32'h0);
        check("spawned", 32'(bus0.spawned), 32'h0);

        phase = "spacing";
        cycle(1, 1, 1, 0);
        for (int s = 1; s <= 9; s++) begin
            cycle(1, 1, 1, 0);
            check("mid_spawned", 32'(bus0.spawned), 32'h0);
            cycle(1, 1, 1, 0);
            check("step_spawned", 32'(bus0.spawned), (s == 1 || s == 5 || s == 9) ? 32'h1 : 32'h0);
            if (s == 1) check("step1_lane", 32'(bus0.lane), 32'h0001);
            if (s == 5) check("step5_lane", 32'(bus0.lane), 32'h0011);
            if (s == 9) check("step9_lane", 32'(bus0.lane), 32'h0111);
        end

        phase = "busy_reset";
        cycle(0, 1, 1, 0);
        check("lane0", 32'(bus0.lane), 32'h0);
        check("lane1", 32'(bus1.lane), 32'h0);
        check("spawned", 32'(bus0.spawned), 32'h0);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        check("idle_first_lane", 32'(bus0.lane), 32'h0);

        phase = "threshold";
        sp_seen = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1, 1, 10'd256);
            if (bus0.spawned) sp_seen++;
        end
        check("no_spawn_count", 32'(sp_seen), 32'h0);
        check("lane_empty", 32'(bus0.lane), 32'h0);
        cycle(1, 1, 1, 10'd255);
        check("lane_255", 32'(bus0.lane), 32'h0001);
        check("spawned_255", 32'(bus0.spawned), 32'h1);

        phase = "freeze";
        cycle(1, 1, 1, 10'd1023);
        cycle(1, 1, 1, 10'd1023);
        check("lane_before", 32'(bus0.lane), 32'h0002);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 1, 10'd0);
            check("lane_hold", 32'(bus0.lane), 32'h0002);
        end
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        check("lane_resume", 32'(bus0.lane), 32'h0005);
        check("spawned_resume", 32'(bus0.spawned), 32'h1);

        phase = "reset_mid_gap";
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        check("lane_gap", 32'(bus0.lane), 32'h000A);
        cycle(0, 1, 1, 0);
        check("lane_rst", 32'(bus0.lane), 32'h0);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        check("lane_spawn", 32'(bus0.lane), 32'h0001);
        check("lane_spawn_dir1", 32'(bus1.lane), 32'h8000);

        phase = "exit";
        for (int i = 0; i < 30; i++) cycle(1, 1, 1, 10'd1023);
        check("lane0_edge", 32'(bus0.lane), 32'h8000);
        check("lane1_edge", 32'(bus1.lane), 32'h0001);
        cycle(1, 1, 0, 10'd1023);
        check("lane0_notick", 32'(bus0.lane), 32'h8000);
        cycle(1, 1, 1, 10'd1023);
        check("lane0_tick1", 32'(bus0.lane), 32'h8000);
        check("lane1_tick1", 32'(bus1.lane), 32'h0001);
        cycle(1, 1, 1, 10'd1023);
        check("lane0_tick2", 32'(bus0.lane), 32'h0000);
        check("lane1_tick2", 32'(bus1.lane), 32'h0000);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 300))
                                              : 10'($urandom_range(0, 1023)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
